tlb_op_unit: RTL and testbench
==============================

// Module: tlb_op_unit
// PURPOSE
//  Sequencer for the CP0 TLB instructions TLBP/TLBR/TLBWI/TLBWR, between the memory stage/CP0 and the TLB array.
//  Drives the TLB write port (tlbwrite_t), the read address and the probe EntryHi. Owns the CP0 Random register.
//  Returns probe/read results to CP0 with a done pulse. One op in flight; the pipeline stalls on op_ready=0.
// PARAMETERS
//  TLB_ENTRIES  16  number of TLB entries; TLB_BIT = $clog2(TLB_ENTRIES)
// PORTS
//  clk           in   1         clock
//  reset         in   1         async reset, active-high
//  op_valid      in   1         TLB instruction request from memory stage
//  op_type       in   2         0=TLBP 1=TLBR 2=TLBWI 3=TLBWR
//  op_ready      out  1         unit idle; request accepted when op_valid&op_ready
//  flush         in   1         pipeline flush (exception/eret in later stage)
//  cp0_index     in   32        CP0 Index; low TLB_BIT bits used
//  cp0_entryhi   in   32        CP0 EntryHi (VPN2[31:13], ASID[7:0])
//  cp0_entrylo0  in   32        CP0 EntryLo0 (PFN[25:6], C[5:3], D[2], V[1], G[0])
//  cp0_entrylo1  in   32        CP0 EntryLo1
//  wired         in   TLB_BIT   CP0 Wired value
//  wired_we      in   1         CP0 write of Wired this cycle
//  tlbw          out  tlbwrite_t  {valid, addr[TLB_BIT], data tlb_entry_t}
//  tlbra         out  TLB_BIT   TLB read address
//  tlbrd         in   tlb_entry_t  TLB read data, combinational from tlbra
//  probe_entryhi out  32        EntryHi presented to the TLB probe lookup
//  probe_index   in   32        probe result; bit31 = miss
//  done          out  1         one-cycle completion pulse (all op types)
//  index_we      out  1         write probe result into CP0 Index (with done, TLBP only)
//  index_out     out  32        value for CP0 Index
//  rd_we         out  1         write EntryHi/Lo0/Lo1 (with done, TLBR only)
//  rd_entryhi, rd_entrylo0, rd_entrylo1  out  32 each  reconstructed CP0 values
//  random        out  TLB_BIT   CP0 Random
// BEHAVIOUR
//  Reset: state IDLE, op_ready=1, tlbw.valid=0, done/index_we/rd_we=0, all data regs 0, random=TLB_ENTRIES-1.
//  FSM IDLE -> {PROBE1, READ, WRITE} on accept; operands (index, entryhi, entrylo0/1, target addr) latched at accept.
//   PROBE1: probe_entryhi = latched EntryHi -> PROBE2: register probe_index -> DONE.  TLBP latency 3 cycles.
//   READ:   tlbra = latched index[TLB_BIT-1:0]; register tlbrd -> DONE.  TLBR latency 2.
//   WRITE:  tlbw.valid=1 for exactly one cycle; addr = index (TLBWI) or random sampled at accept (TLBWR) -> DONE.
//   DONE:   done=1 (plus index_we or rd_we as per op), then IDLE. op_ready=1 only in IDLE.
//  Entry pack: vpn2=EntryHi[31:13], asid=EntryHi[7:0], G = Lo0.G & Lo1.G, pfn/c/d/v per page.
//  Entry unpack (TLBR): EntryHi={vpn2,5'b0,asid}; Lo0/Lo1={6'b0,pfn,c,d,v,G}, G copied into both.
//  index_out = {miss, 0.., addr}; on miss addr bits = 0.
//  Random: each cycle, if random==wired or random==TLB_ENTRIES-1... decrement rule:
//   random <= (random==wired) ? TLB_ENTRIES-1 : random-1; never below wired.
//   wired_we: random <= TLB_ENTRIES-1 that cycle (overrides decrement). wired >= TLB_ENTRIES-1: random held at TLB_ENTRIES-1.
//   TLBWR write consumes the sampled value; decrement continues normally.
//  flush: in PROBE1/PROBE2/READ -> IDLE next cycle, no done, no CP0 writes. In WRITE/DONE flush is ignored
//   (write committed). flush with op_valid in IDLE: request not accepted.
//  Async reset mid-op: everything returns to reset values immediately; no partial tlbw pulse after release.
//  TLBWI index >= TLB_ENTRIES: address truncated to TLB_BIT bits (modulo).
// STRUCTURE
//  Package (pipeline.svh): tlb_entry_t, tlbwrite_t, tlb_addr_t, TLB_ENTRIES/TLB_BIT, tlb_op_t enum,
//   pack_entry()/unpack_entry() functions shared with CP0.
//  One sub-module: tlb_random_reg (Random counter with Wired floor, wired_we reload).
// TESTING
//  Reset -> random=15, op_ready=1, tlbw.valid=0; no wired write, 20 cycles, wired=0 -> random wraps 15..0..15.
//  wired=4 written -> random=15 next cycle, then descends to 4, wraps to 15; never reads 3.
//  TLBWI idx=5, EntryHi=0x0040_2012, Lo0=0x0000_1047, Lo1=0x0000_1086 -> 1-cycle tlbw to addr 5, G=0, done 2 cycles later.
//  TLBR idx 5 after above -> rd_we with EntryHi=0x0040_2012, Lo0=0x0000_1046, Lo1=0x0000_1086 (G=0 both).
//  TLBP matching entry 5 -> index_out=0x0000_0005; non-matching -> 0x8000_0000; latency 3 cycles.
//  flush in PROBE2 -> no done/index_we, op_ready back next cycle; flush in WRITE -> write and done still occur.

Source files
------------

// File: rtl/tlb_op_unit_pkg.sv
// Shared TLB types for the TLB op sequencer and CP0: entry layout, write port,
// op encoding and the CP0 <-> entry conversion helpers.
package tlb_op_unit_pkg;

   localparam int unsigned TLB_ENTRIES = 16;
   localparam int unsigned TLB_BIT     = $clog2(TLB_ENTRIES);

   typedef logic [TLB_BIT-1:0] tlb_addr_t;

   localparam tlb_addr_t TLB_LAST = tlb_addr_t'(TLB_ENTRIES - 1);

   typedef enum logic [1:0] {
      OP_TLBP  = 2'd0,
      OP_TLBR  = 2'd1,
      OP_TLBWI = 2'd2,
      OP_TLBWR = 2'd3
   } tlb_op_t;

   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } tlb_page_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      tlb_page_t   p0;
      tlb_page_t   p1;
   } tlb_entry_t;

   typedef struct packed {
      logic       valid;
      tlb_addr_t  addr;
      tlb_entry_t data;
   } tlbwrite_t;

   typedef struct packed {
      logic [31:0] entryhi;
      logic [31:0] entrylo0;
      logic [31:0] entrylo1;
   } cp0_tlb_regs_t;

   // Global bit is only set when both pages are global.
   function automatic tlb_entry_t pack_entry(input logic [31:0] hi,
                                             input logic [31:0] lo0,
                                             input logic [31:0] lo1);
      tlb_entry_t e;
      logic       unused_f;
      unused_f  = ^{hi[12:8], lo0[31:26], lo1[31:26]};
      e.vpn2    = hi[31:13];
      e.asid    = hi[7:0];
      e.g       = lo0[0] & lo1[0];
      e.p0.pfn  = lo0[25:6];
      e.p0.c    = lo0[5:3];
      e.p0.d    = lo0[2];
      e.p0.v    = lo0[1];
      e.p1.pfn  = lo1[25:6];
      e.p1.c    = lo1[5:3];
      e.p1.d    = lo1[2];
      e.p1.v    = lo1[1];
      return e;
   endfunction

   function automatic cp0_tlb_regs_t unpack_entry(input tlb_entry_t e);
      cp0_tlb_regs_t r;
      r.entryhi  = {e.vpn2, 5'b0, e.asid};
      r.entrylo0 = {6'b0, e.p0.pfn, e.p0.c, e.p0.d, e.p0.v, e.g};
      r.entrylo1 = {6'b0, e.p1.pfn, e.p1.c, e.p1.d, e.p1.v, e.g};
      return r;
   endfunction

endpackage

// File: rtl/tlb_random_reg.sv
// CP0 Random register: free-running down-counter that wraps to the top entry
// when it reaches Wired, and reloads on any Wired write.
module tlb_random_reg
   import tlb_op_unit_pkg::*;
(
   input  logic      clk_i,
   input  logic      reset_i,
   input  tlb_addr_t wired_i,
   input  logic      wired_we_i,
   output tlb_addr_t random_o
);

   tlb_addr_t random_q, random_d;

   always_comb begin
      random_d = random_q - tlb_addr_t'(1);
      if (wired_we_i || (wired_i >= TLB_LAST) || (random_q == wired_i)) begin
         random_d = TLB_LAST;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) random_q <= TLB_LAST;
      else         random_q <= random_d;
   end

   assign random_o = random_q;

endmodule

// File: rtl/tlb_op_unit.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR: latches operands at accept, drives the
// TLB write/read/probe ports and returns results to CP0 with a done pulse.
module tlb_op_unit
   import tlb_op_unit_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        op_valid_i,
   input  logic [1:0]  op_type_i,
   output logic        op_ready_o,
   input  logic        flush_i,
   input  logic [31:0] cp0_index_i,
   input  logic [31:0] cp0_entryhi_i,
   input  logic [31:0] cp0_entrylo0_i,
   input  logic [31:0] cp0_entrylo1_i,
   input  tlb_addr_t   wired_i,
   input  logic        wired_we_i,
   output tlbwrite_t   tlbw_o,
   output tlb_addr_t   tlbra_o,
   input  tlb_entry_t  tlbrd_i,
   output logic [31:0] probe_entryhi_o,
   input  logic [31:0] probe_index_i,
   output logic        done_o,
   output logic        index_we_o,
   output logic [31:0] index_out_o,
   output logic        rd_we_o,
   output logic [31:0] rd_entryhi_o,
   output logic [31:0] rd_entrylo0_o,
   output logic [31:0] rd_entrylo1_o,
   output tlb_addr_t   random_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_PROBE1, S_PROBE2, S_READ, S_WRITE, S_DONE
   } state_t;

   state_t        state_q, state_d;
   tlb_op_t       op_q, op_d;
   tlb_addr_t     addr_q, addr_d;
   logic [31:0]   entryhi_q, entryhi_d;
   tlb_entry_t    wdata_q, wdata_d;
   logic [31:0]   index_out_q, index_out_d;
   cp0_tlb_regs_t rd_q, rd_d;
   logic          wvalid_q, wvalid_d;
   logic          op_ready_q, op_ready_d;
   logic          done_q, done_d;
   logic          index_we_q, index_we_d;
   logic          rd_we_q, rd_we_d;
   tlb_addr_t     random;
   logic          unused_bits;

   assign unused_bits = ^{cp0_index_i[31:TLB_BIT], probe_index_i[30:TLB_BIT]};

   tlb_random_reg u_random (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .wired_i    (wired_i),
      .wired_we_i (wired_we_i),
      .random_o   (random)
   );

   // Flush only cancels ops that have not yet touched the TLB or CP0.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      entryhi_d   = entryhi_q;
      wdata_d     = wdata_q;
      index_out_d = index_out_q;
      rd_d        = rd_q;
      unique case (state_q)
         S_IDLE: begin
            if (op_valid_i && !flush_i) begin
               op_d      = tlb_op_t'(op_type_i);
               entryhi_d = cp0_entryhi_i;
               wdata_d   = pack_entry(cp0_entryhi_i, cp0_entrylo0_i, cp0_entrylo1_i);
               addr_d    = (op_d == OP_TLBWR) ? random : cp0_index_i[TLB_BIT-1:0];
               unique case (op_d)
                  OP_TLBP: state_d = S_PROBE1;
                  OP_TLBR: state_d = S_READ;
                  default: state_d = S_WRITE;
               endcase
            end
         end
         S_PROBE1: state_d = flush_i ? S_IDLE : S_PROBE2;
         S_PROBE2: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               index_out_d = probe_index_i[31] ? 32'h8000_0000
                                               : 32'(probe_index_i[TLB_BIT-1:0]);
               state_d     = S_DONE;
            end
         end
         S_READ: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               rd_d    = unpack_entry(tlbrd_i);
               state_d = S_DONE;
            end
         end
         S_WRITE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      op_ready_d = (state_d == S_IDLE);
      wvalid_d   = (state_d == S_WRITE);
      done_d     = (state_d == S_DONE);
      index_we_d = done_d && (op_d == OP_TLBP);
      rd_we_d    = done_d && (op_d == OP_TLBR);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         op_q        <= OP_TLBP;
         addr_q      <= '0;
         entryhi_q   <= '0;
         wdata_q     <= '0;
         index_out_q <= '0;
         rd_q        <= '0;
         wvalid_q    <= 1'b0;
         op_ready_q  <= 1'b1;
         done_q      <= 1'b0;
         index_we_q  <= 1'b0;
         rd_we_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         entryhi_q   <= entryhi_d;
         wdata_q     <= wdata_d;
         index_out_q <= index_out_d;
         rd_q        <= rd_d;
         wvalid_q    <= wvalid_d;
         op_ready_q  <= op_ready_d;
         done_q      <= done_d;
         index_we_q  <= index_we_d;
         rd_we_q     <= rd_we_d;
      end
   end

   assign tlbw_o          = '{valid: wvalid_q, addr: addr_q, data: wdata_q};
   assign tlbra_o         = addr_q;
   assign probe_entryhi_o = entryhi_q;
   assign op_ready_o      = op_ready_q;
   assign done_o          = done_q;
   assign index_we_o      = index_we_q;
   assign index_out_o     = index_out_q;
   assign rd_we_o         = rd_we_q;
   assign rd_entryhi_o    = rd_q.entryhi;
   assign rd_entrylo0_o   = rd_q.entrylo0;
   assign rd_entrylo1_o   = rd_q.entrylo1;
   assign random_o        = random;

endmodule

// File: tb/tb_tlb_op_unit.sv
// Scoreboard bench for tlb_op_unit: CP0-level reference model of the TLB
// contents and Random, a behavioural TLB array, and a decoupled monitor.
module tb_tlb_op_unit;
   import tlb_op_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid, op_ready, flush, wired_we;
   logic [1:0]  op_type;
   logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
   tlb_addr_t   wired, tlbra, random;
   tlbwrite_t   tlbw;
   tlb_entry_t  tlbrd;
   logic [31:0] probe_entryhi, probe_index, index_out;
   logic        done, index_we, rd_we;
   logic [31:0] rd_entryhi, rd_entrylo0, rd_entrylo1;

   tlb_op_unit dut (
      .clk_i(clk), .reset_i(reset), .op_valid_i(op_valid), .op_type_i(op_type),
      .op_ready_o(op_ready), .flush_i(flush), .cp0_index_i(cp0_index),
      .cp0_entryhi_i(cp0_entryhi), .cp0_entrylo0_i(cp0_entrylo0),
      .cp0_entrylo1_i(cp0_entrylo1), .wired_i(wired), .wired_we_i(wired_we),
      .tlbw_o(tlbw), .tlbra_o(tlbra), .tlbrd_i(tlbrd),
      .probe_entryhi_o(probe_entryhi), .probe_index_i(probe_index),
      .done_o(done), .index_we_o(index_we), .index_out_o(index_out),
      .rd_we_o(rd_we), .rd_entryhi_o(rd_entryhi), .rd_entrylo0_o(rd_entrylo0),
      .rd_entrylo1_o(rd_entrylo1), .random_o(random)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Behavioural TLB array the DUT talks to.
   tlb_entry_t mem [TLB_ENTRIES];
   logic       mem_clr;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < TLB_ENTRIES; i++) mem[i] <= '0;
      end else if (tlbw.valid) begin
         mem[tlbw.addr] <= tlbw.data;
      end
   end
   assign tlbrd = mem[tlbra];
   always_comb begin
      probe_index = 32'h8000_0000;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--)
         if (mem[i].vpn2 == probe_entryhi[31:13] &&
             (mem[i].g || mem[i].asid == probe_entryhi[7:0]))
            probe_index = 32'(i);
   end

   // Reference model: TLB contents as the CP0 words TLBR would return.
   logic [31:0] m_hi [TLB_ENTRIES];
   logic [31:0] m_lo0 [TLB_ENTRIES];
   logic [31:0] m_lo1 [TLB_ENTRIES];
   tlb_addr_t   rand_m;

   always @(posedge clk or posedge reset) begin
      if (reset)                                  rand_m <= 4'(TLB_ENTRIES - 1);
      else if (wired_we)                          rand_m <= 4'(TLB_ENTRIES - 1);
      else if (int'(wired) >= TLB_ENTRIES - 1)    rand_m <= 4'(TLB_ENTRIES - 1);
      else if (rand_m == wired)                   rand_m <= 4'(TLB_ENTRIES - 1);
      else                                        rand_m <= rand_m - 4'd1;
   end

   function automatic logic [31:0] probe_model(input logic [31:0] hi);
      for (int i = 0; i < TLB_ENTRIES; i++)
         if ((m_hi[i] >> 13) == (hi >> 13) && (m_lo0[i][0] || m_hi[i][7:0] == hi[7:0]))
            return 32'(i);
      return 32'h8000_0000;
   endfunction

   typedef struct { tlb_addr_t addr; logic [31:0] hi, lo0, lo1; } wr_exp_t;
   typedef struct { tlb_op_t op; int cyc; logic [31:0] idx, hi, lo0, lo1; } done_exp_t;
   wr_exp_t   wq[$];
   done_exp_t dq[$];

   // Monitor: compares every DUT output event against the scoreboard.
   always @(negedge clk) begin : mon
      wr_exp_t     w;
      done_exp_t   d;
      logic [31:0] whi, wlo0, wlo1;
      if (reset) begin
         wq.delete();
         dq.delete();
      end else begin
         chk("random", 32'(random), 32'(rand_m));
         if (!wired_we) chk("random_floor", 32'(random >= wired), 32'd1);
         if (tlbw.valid) begin
            if (wq.size() == 0) chk("tlbw_unexpected", 32'(tlbw.valid), 32'd0);
            else begin
               w    = wq.pop_front();
               whi  = {tlbw.data.vpn2, 5'b0, tlbw.data.asid};
               wlo0 = {6'b0, tlbw.data.p0.pfn, tlbw.data.p0.c, tlbw.data.p0.d, tlbw.data.p0.v, tlbw.data.g};
               wlo1 = {6'b0, tlbw.data.p1.pfn, tlbw.data.p1.c, tlbw.data.p1.d, tlbw.data.p1.v, tlbw.data.g};
               chk("tlbw_addr", 32'(tlbw.addr), 32'(w.addr));
               chk("tlbw_hi", whi, w.hi);
               chk("tlbw_lo0", wlo0, w.lo0);
               chk("tlbw_lo1", wlo1, w.lo1);
            end
         end
         if (done) begin
            if (dq.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
            else begin
               d = dq.pop_front();
               chk("done_latency", 32'(cyc), 32'(d.cyc));
               chk("index_we", 32'(index_we), 32'(d.op == OP_TLBP));
               chk("rd_we", 32'(rd_we), 32'(d.op == OP_TLBR));
               if (d.op == OP_TLBP) chk("index_out", index_out, d.idx);
               if (d.op == OP_TLBR) begin
                  chk("rd_entryhi", rd_entryhi, d.hi);
                  chk("rd_entrylo0", rd_entrylo0, d.lo0);
                  chk("rd_entrylo1", rd_entrylo1, d.lo1);
               end
            end
         end else if (index_we || rd_we) begin
            chk("we_without_done", 32'({index_we, rd_we}), 32'd0);
         end
         if (dq.size() > 0 && dq[0].cyc < cyc) begin
            chk("done_missing", 32'(done), 32'd1);
            void'(dq.pop_front());
         end
      end
   end

   // Issue one op; fl>0 raises flush during the fl-th cycle after accept.
   task automatic issue(input tlb_op_t op, input logic [31:0] idx, input logic [31:0] hi,
                        input logic [31:0] lo0, input logic [31:0] lo1, input int fl);
      int        n;
      int        acc;
      tlb_addr_t rs, a;
      logic      g, cancel;
      done_exp_t d;
      n = 0;
      while (!op_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!op_ready) begin
         chk("ready_timeout", 32'(op_ready), 32'd1);
         return;
      end
      op_valid = 1'b1; op_type = op; cp0_index = idx;
      cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
      rs = rand_m;
      @(posedge clk); #1;
      op_valid = 1'b0;
      acc = cyc;
      a = (op == OP_TLBWR) ? rs : tlb_addr_t'(idx % TLB_ENTRIES);
      cancel = (fl != 0) && ((op == OP_TLBP && fl <= 2) || (op == OP_TLBR && fl == 1));
      if (op == OP_TLBWI || op == OP_TLBWR) begin
         g = lo0[0] & lo1[0];
         m_hi[a]  = hi & 32'hFFFF_E0FF;
         m_lo0[a] = (lo0 & 32'h03FF_FFFE) | 32'(g);
         m_lo1[a] = (lo1 & 32'h03FF_FFFE) | 32'(g);
         wq.push_back('{addr: a, hi: m_hi[a], lo0: m_lo0[a], lo1: m_lo1[a]});
      end
      d.op  = op;
      d.cyc = acc + ((op == OP_TLBP) ? 3 : 2) - 1;
      d.idx = (op == OP_TLBP) ? probe_model(hi) : 32'd0;
      d.hi  = m_hi[a];
      d.lo0 = m_lo0[a];
      d.lo1 = m_lo1[a];
      if (!cancel) dq.push_back(d);
      if (fl > 0) begin
         repeat (fl - 1) begin @(posedge clk); #1; end
         flush = 1'b1;
         @(posedge clk); #1;
         flush = 1'b0;
         if (cancel) begin
            @(negedge clk);
            chk("flush_ready", 32'(op_ready), 32'd1);
         end
      end
   endtask

   task automatic set_wired(input tlb_addr_t w);
      wired = w; wired_we = 1'b1;
      @(posedge clk); #1;
      wired_we = 1'b0;
   endtask

   initial begin
      logic [18:0] vpool [4];
      logic [7:0]  apool [2];
      tlb_op_t     op;
      int          fl;
      vpool[0] = 19'h00201; vpool[1] = 19'h7FFFF; vpool[2] = 19'h12345; vpool[3] = 19'h0;
      apool[0] = 8'h12; apool[1] = 8'h34;
      for (int i = 0; i < TLB_ENTRIES; i++) begin m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0; end
      reset = 1'b1; mem_clr = 1'b1; op_valid = 1'b0; op_type = 2'd0; flush = 1'b0;
      cp0_index = '0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
      wired = '0; wired_we = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_op_ready", 32'(op_ready), 32'd1);
      chk("rst_tlbw_valid", 32'(tlbw.valid), 32'd0);
      chk("rst_random", 32'(random), 32'd15);
      chk("rst_done", 32'({done, index_we, rd_we}), 32'd0);
      chk("rst_index_out", index_out, 32'd0);
      chk("rst_rd_entryhi", rd_entryhi, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; mem_clr = 1'b0;

      repeat (20) @(posedge clk);
      #1;
      set_wired(4'd4);
      @(negedge clk);
      chk("random_reload", 32'(random), 32'd15);
      repeat (30) @(posedge clk);
      #1;

      issue(OP_TLBWI, 32'd5, 32'h0040_2012, 32'h0000_1047, 32'h0000_1086, 0);
      issue(OP_TLBR,  32'd5, 32'h0, 32'h0, 32'h0, 0);
      issue(OP_TLBP,  32'd0, 32'h0040_2012, 32'h0, 32'h0, 0);
      issue(OP_TLBP,  32'd0, 32'h1234_0000, 32'h0, 32'h0, 0);
      issue(OP_TLBP,  32'd0, 32'h0040_2012, 32'h0, 32'h0, 2);
      issue(OP_TLBR,  32'd5, 32'h0, 32'h0, 32'h0, 1);
      issue(OP_TLBWI, 32'd7, 32'h1111_2022, 32'h0000_0003, 32'h0000_0007, 1);
      issue(OP_TLBR,  32'd7, 32'h0, 32'h0, 32'h0, 0);
      issue(OP_TLBP,  32'd0, 32'h1111_20FF, 32'h0, 32'h0, 0);
      issue(OP_TLBWR, 32'd0, 32'h2468_A055, 32'h0000_2FFF, 32'h0000_3FFF, 0);
      issue(OP_TLBWI, 32'hFFFF_FFF3, 32'h0246_0034, 32'h03FF_FFFE, 32'h0000_0001, 2);
      issue(OP_TLBR,  32'd3, 32'h0, 32'h0, 32'h0, 0);

      // Flush together with a request in IDLE must not accept it.
      while (!op_ready) begin @(posedge clk); #1; end
      op_valid = 1'b1; op_type = OP_TLBP; flush = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_idle_not_accepted", 32'(op_ready), 32'd1);
      @(posedge clk); #1;

      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 7) == 0) set_wired(4'($urandom_range(0, 15)));
         op = tlb_op_t'(2'($urandom_range(0, 3)));
         fl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
         issue(op, $urandom,
               {vpool[$urandom_range(0, 3)], 5'($urandom), apool[$urandom_range(0, 1)]},
               $urandom, $urandom, fl);
      end

      // Async reset in the middle of a probe.
      issue(OP_TLBP, 32'd0, 32'h0040_2012, 32'h0, 32'h0, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_ready", 32'(op_ready), 32'd1);
      chk("async_rst_random", 32'(random), 32'd15);
      chk("async_rst_outputs", 32'({done, index_we, rd_we, tlbw.valid}), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("pending_done", 32'(dq.size()), 32'd0);
      chk("pending_write", 32'(wq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
